// File: rtl/pbs_ctrl.sv
// pbs_ctrl: turn sequencer for the battle datapath.
// Runs one player attack and then one AI attack per round. After each
// attack it checks the HP value fed back from the datapath, detects a
// knock-out and latches the winner. Every output is registered: the
// output values for the next cycle are decoded from the next state.
module pbs_ctrl #(
    parameter int unsigned AI_DELAY = 8,
    parameter int unsigned TURN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    input  logic [1:0]        p_move_in,
    input  logic [3:0]        p_hp,
    input  logic [3:0]        AI_hp,
    output logic [1:0]        p_move,
    output logic              actr,
    output logic              target,
    output logic              app_dmg,
    output logic              busy,
    output logic              game_over,
    output logic              winner,
    output logic [2:0]        state_dbg,
    output logic [TURN_W-1:0] round_cnt
);

    typedef enum logic [3:0] {
        WAIT_P  = 4'd0,
        P_SEL   = 4'd1,
        P_HIT   = 4'd2,
        P_CHK   = 4'd3,
        AI_WAIT = 4'd4,
        AI_SEL  = 4'd5,
        AI_HIT  = 4'd6,
        AI_CHK  = 4'd7,
        OVER    = 4'd8
    } state_t;

    localparam logic [7:0] DLY_LOAD = 8'(AI_DELAY - 1);

    state_t            state, state_nx;
    logic [7:0]        dly, dly_nx;
    logic [1:0]        p_move_nx;
    logic              winner_nx;
    logic [TURN_W-1:0] round_nx;
    logic              actr_nx, target_nx, app_dmg_nx, busy_nx, game_over_nx;
    logic [2:0]        state_dbg_nx;

    // Next-state, datapath bookkeeping and next-cycle Moore outputs
    always_comb begin
        state_nx  = state;
        dly_nx    = dly;
        p_move_nx = p_move;
        winner_nx = winner;
        round_nx  = round_cnt;

        case (state)
            WAIT_P: begin
                if (move_valid) begin
                    p_move_nx = p_move_in;
                    state_nx  = P_SEL;
                end
            end
            P_SEL:  state_nx = P_HIT;
            P_HIT:  state_nx = P_CHK;
            P_CHK: begin
                if (AI_hp == 4'd0) begin
                    winner_nx = 1'b0;
                    state_nx  = OVER;
                end else begin
                    dly_nx   = DLY_LOAD;
                    state_nx = AI_WAIT;
                end
            end
            AI_WAIT: begin
                if (dly == 8'd0) begin
                    state_nx = AI_SEL;
                end else begin
                    dly_nx = dly - 8'd1;
                end
            end
            AI_SEL: state_nx = AI_HIT;
            AI_HIT: state_nx = AI_CHK;
            AI_CHK: begin
                if (p_hp == 4'd0) begin
                    winner_nx = 1'b1;
                    state_nx  = OVER;
                end else begin
                    if (round_cnt != '1) begin
                        round_nx = round_cnt + TURN_W'(1);
                    end
                    state_nx = WAIT_P;
                end
            end
            OVER:    state_nx = OVER;
            default: state_nx = WAIT_P;
        endcase

        // Outputs follow the state being entered, so they change only on
        // the state-entry edge and stay stable through the app_dmg cycle.
        actr_nx      = 1'b0;
        target_nx    = 1'b1;
        app_dmg_nx   = 1'b0;
        busy_nx      = 1'b1;
        game_over_nx = 1'b0;
        state_dbg_nx = state_nx[2:0];

        case (state_nx)
            AI_WAIT, AI_SEL, AI_HIT, AI_CHK: begin
                actr_nx   = 1'b1;
                target_nx = 1'b0;
            end
            default: ;
        endcase

        if (state_nx == P_HIT || state_nx == AI_HIT) begin
            app_dmg_nx = 1'b1;
        end

        if (state_nx == WAIT_P || state_nx == OVER) begin
            busy_nx = 1'b0;
        end

        if (state_nx == OVER) begin
            game_over_nx = 1'b1;
            state_dbg_nx = 3'd7;
        end
    end

    // State and registered outputs; reset wins over every other event
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_P;
            dly       <= '0;
            p_move    <= '0;
            winner    <= 1'b0;
            round_cnt <= '0;
            actr      <= 1'b0;
            target    <= 1'b1;
            app_dmg   <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            state_dbg <= '0;
        end else begin
            state     <= state_nx;
            dly       <= dly_nx;
            p_move    <= p_move_nx;
            winner    <= winner_nx;
            round_cnt <= round_nx;
            actr      <= actr_nx;
            target    <= target_nx;
            app_dmg   <= app_dmg_nx;
            busy      <= busy_nx;
            game_over <= game_over_nx;
            state_dbg <= state_dbg_nx;
        end
    end

endmodule
